// File: rtl/video_stream_checker.sv
// AXI4-Stream video sink: generates (optionally random) backpressure, checks
// frame structure and reports a per-frame checksum plus a good-frame counter.
module video_stream_checker #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_vid_tdata,
  input  logic        s_axis_vid_tlast,
  input  logic        s_axis_vid_tuser,
  input  logic        s_axis_vid_tvalid,
  output logic        s_axis_vid_tready,
  input  logic        stall_en,
  input  logic        err_clr,
  output logic [15:0] frame_count,
  output logic [31:0] checksum,
  output logic        checksum_valid,
  output logic        sof_err,
  output logic        eol_early_err,
  output logic        eol_late_err
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [31:0]   r_acc;
  logic          r_frame_err;

  logic          w_xfer;
  logic          w_at_origin;
  logic          w_drop;
  logic          w_pix;
  logic          w_sof_new;
  logic [XW-1:0] w_bx;
  logic [YW-1:0] w_by;
  logic [31:0]   w_bacc;
  logic          w_berr;
  logic          w_early;
  logic          w_late;
  logic          w_eol;
  logic          w_eof;
  logic [31:0]   w_sum;
  logic          w_bad;
  logic [15:0]   w_lfsr_next;

  assign w_xfer      = s_axis_vid_tvalid & s_axis_vid_tready;
  assign w_at_origin = (r_x == '0) && (r_y == '0);

  // A beat without tuser where pixel (0,0) is expected is thrown away.
  assign w_drop    = !s_axis_vid_tuser & ((r_state == ST_SYNC) | w_at_origin);
  assign w_pix     = w_xfer & !w_drop;
  assign w_sof_new = w_xfer & (r_state == ST_ACTIVE) &
                     (w_at_origin ? !s_axis_vid_tuser : s_axis_vid_tuser);

  // Any tuser beat is pixel (0,0) of a fresh frame, so position/sum restart.
  assign w_bx   = s_axis_vid_tuser ? '0    : r_x;
  assign w_by   = s_axis_vid_tuser ? '0    : r_y;
  assign w_bacc = s_axis_vid_tuser ? '0    : r_acc;
  assign w_berr = s_axis_vid_tuser ? 1'b0  : r_frame_err;

  assign w_early = s_axis_vid_tlast & (w_bx != X_LAST);
  assign w_late  = !s_axis_vid_tlast & (w_bx == X_LAST);
  assign w_eol   = s_axis_vid_tlast | (w_bx == X_LAST);
  assign w_eof   = w_eol & (w_by == Y_LAST);
  assign w_sum   = w_bacc + s_axis_vid_tdata;
  assign w_bad   = w_berr | w_early | w_late;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state           <= ST_SYNC;
      r_lfsr            <= LFSR_SEED;
      r_x               <= '0;
      r_y               <= '0;
      r_acc             <= '0;
      r_frame_err       <= 1'b0;
      s_axis_vid_tready <= 1'b0;
      frame_count       <= '0;
      checksum          <= '0;
      checksum_valid    <= 1'b0;
      sof_err           <= 1'b0;
      eol_early_err     <= 1'b0;
      eol_late_err      <= 1'b0;
    end else begin
      r_lfsr            <= w_lfsr_next;
      s_axis_vid_tready <= !stall_en | r_lfsr[0] | r_lfsr[1];
      checksum_valid    <= 1'b0;
      sof_err           <= (sof_err & !err_clr) | w_sof_new;
      eol_early_err     <= (eol_early_err & !err_clr) | (w_pix & w_early);
      eol_late_err      <= (eol_late_err & !err_clr) | (w_pix & w_late);

      if (w_xfer) begin
        if (w_drop) begin
          r_state <= ST_SYNC;
        end else begin
          r_state <= ST_ACTIVE;
          if (w_eof) begin
            r_x            <= '0;
            r_y            <= '0;
            r_acc          <= '0;
            r_frame_err    <= 1'b0;
            checksum       <= w_sum;
            checksum_valid <= 1'b1;
            if (!w_bad)
              frame_count <= frame_count + 16'd1;
          end else if (w_eol) begin
            r_x         <= '0;
            r_y         <= w_by + YW'(1);
            r_acc       <= w_sum;
            r_frame_err <= w_bad;
          end else begin
            r_x         <= w_bx + XW'(1);
            r_y         <= w_by;
            r_acc       <= w_sum;
            r_frame_err <= w_bad;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Randomised bench for video_stream_checker with a frame-level reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_video_stream_checker;

  localparam int H = 4;
  localparam int V = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tlast, tuser, tvalid, tready;
  logic        stall_en, err_clr;
  logic [15:0] frame_count;
  logic [31:0] checksum;
  logic        checksum_valid, sof_err, eol_early_err, eol_late_err;

  int n_checks = 0;
  int n_errs   = 0;

  video_stream_checker #(.H_RES(H), .V_RES(V), .LFSR_SEED(SEED)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_vid_tdata(tdata), .s_axis_vid_tlast(tlast),
    .s_axis_vid_tuser(tuser), .s_axis_vid_tvalid(tvalid),
    .s_axis_vid_tready(tready), .stall_en(stall_en), .err_clr(err_clr),
    .frame_count(frame_count), .checksum(checksum), .checksum_valid(checksum_valid),
    .sof_err(sof_err), .eol_early_err(eol_early_err), .eol_late_err(eol_late_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: position in frame, pixels of the current frame
  bit          m_rdy;
  logic [15:0] m_lfsr;
  bit          m_active;
  int          m_px, m_py;
  bit          m_bad;
  logic [31:0] fq[$];
  logic [15:0] e_fc;
  logic [31:0] e_cs;
  bit          e_cv, e_sof, e_early, e_late;

  task automatic model_reset();
    m_rdy = 0; m_lfsr = SEED; m_active = 0; m_px = 0; m_py = 0; m_bad = 0;
    fq.delete();
    e_fc = 0; e_cs = 0; e_cv = 0; e_sof = 0; e_early = 0; e_late = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit u, input bit l);
    bit at0, lastpx;
    logic [31:0] s;
    at0 = (m_px == 0) && (m_py == 0);
    if (!m_active) begin
      if (!u) return;
    end else if (at0 && !u) begin
      e_sof = 1; m_active = 0;
      return;
    end
    if (u) begin
      if (m_active && !at0) e_sof = 1;
      m_px = 0; m_py = 0; m_bad = 0; fq.delete(); m_active = 1;
    end
    fq.push_back(d);
    lastpx = (m_px == H - 1);
    if (l && !lastpx) begin e_early = 1; m_bad = 1; end
    if (!l && lastpx) begin e_late = 1; m_bad = 1; end
    if (l || lastpx) begin
      if (m_py == V - 1) begin
        s = 0;
        foreach (fq[i]) s += fq[i];
        e_cs = s;
        if (!m_bad) e_fc = e_fc + 16'd1;
        e_cv = 1;
        fq.delete(); m_px = 0; m_py = 0; m_bad = 0;
      end else begin
        m_px = 0; m_py++;
      end
    end else begin
      m_px++;
    end
  endtask

  // Compare, then advance the model with the inputs the next rising edge samples.
  initial begin
    model_reset();
    forever begin
      @(negedge aclk);
      if (!aresetn) model_reset();
      check("tready",         {31'd0, tready},         {31'd0, m_rdy});
      check("frame_count",    {16'd0, frame_count},    {16'd0, e_fc});
      check("checksum",       checksum,                e_cs);
      check("checksum_valid", {31'd0, checksum_valid}, {31'd0, e_cv});
      check("sof_err",        {31'd0, sof_err},        {31'd0, e_sof});
      check("eol_early_err",  {31'd0, eol_early_err},  {31'd0, e_early});
      check("eol_late_err",   {31'd0, eol_late_err},   {31'd0, e_late});
      if (aresetn) begin
        e_cv = 0;
        if (err_clr) begin e_sof = 0; e_early = 0; e_late = 0; end
        if (tvalid && m_rdy) model_beat(tdata, tuser, tlast);
        m_rdy  = !stall_en || m_lfsr[0] || m_lfsr[1];
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
    end
  end

  task automatic idle(input int k);
    tvalid = 0;
    repeat (k) begin @(posedge aclk); #1; end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int  n;
    bit  rdy;
    tdata = d; tuser = u; tlast = l; tvalid = 1;
    n = 0;
    forever begin
      @(negedge aclk);
      rdy = tready;
      @(posedge aclk); #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        n_errs++; n_checks++;
        $display("FAIL handshake at %0t: tready stuck low, expected 1", $time);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] base, input bit gaps);
    for (int i = 0; i < H * V; i++) begin
      if (gaps && ($urandom % 3 == 0)) idle($urandom_range(1, 2));
      send_beat(base + i, i == 0, (i % H) == H - 1);
    end
    tvalid = 0;
  endtask

  task automatic frame_done(input string tag, input logic [31:0] cs, input logic [15:0] fc);
    @(negedge aclk);
    check({tag, "_cv"}, {31'd0, checksum_valid}, 32'd1);
    check({tag, "_cs"}, checksum, cs);
    check({tag, "_fc"}, {16'd0, frame_count}, {16'd0, fc});
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    @(posedge aclk); #1;
    err_clr = 0;
  endtask

  initial begin
    aresetn = 0; tdata = 0; tlast = 0; tuser = 0; tvalid = 0;
    stall_en = 0; err_clr = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tready", {31'd0, tready}, 32'd0);
    check("rst_fc", {16'd0, frame_count}, 32'd0);
    check("rst_cs", checksum, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1;
    @(negedge aclk);
    check("rel_tready0", {31'd0, tready}, 32'd0);
    @(negedge aclk);
    check("rel_tready1", {31'd0, tready}, 32'd1);
    @(posedge aclk); #1;

    // Junk before the first start-of-frame
    for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'(i == 2));
    tvalid = 0;
    @(negedge aclk);
    check("junk_sof", {31'd0, sof_err}, 32'd0);
    @(posedge aclk); #1;

    send_frame(32'd1, 0);
    frame_done("clean1", 32'd78, 16'd1);
    @(negedge aclk);
    check("cv_one_pulse", {31'd0, checksum_valid}, 32'd0);
    @(posedge aclk); #1;
    send_frame(32'd1, 0);
    frame_done("clean2", 32'd78, 16'd2);
    @(posedge aclk); #1;

    stall_en = 1;
    send_frame(32'd1, 0);
    frame_done("stall1", 32'd78, 16'd3);
    @(posedge aclk); #1;
    send_frame(32'd1, 1);
    frame_done("stall2", 32'd78, 16'd4);
    check("stall_noerr", {29'd0, sof_err, eol_early_err, eol_late_err}, 32'd0);
    @(posedge aclk); #1;
    stall_en = 0;

    // Early tlast on pixel 2 of line 0: 3 + 4 + 4 beats
    for (int i = 1; i <= 11; i++)
      send_beat(i, i == 1, (i == 3) || (i == 7) || (i == 11));
    tvalid = 0;
    frame_done("early", 32'd66, 16'd4);
    check("early_flag", {31'd0, eol_early_err}, 32'd1);
    @(posedge aclk); #1;
    pulse_clr();
    @(negedge aclk);
    check("early_clr", {31'd0, eol_early_err}, 32'd0);
    @(posedge aclk); #1;

    // tuser reasserted at pixel (1,1)
    for (int i = 0; i < 5; i++) send_beat(50 + i, i == 0, i == 3);
    for (int i = 0; i < H * V; i++) send_beat(100 + i, i == 0, (i % H) == H - 1);
    tvalid = 0;
    frame_done("restart", 32'd1266, 16'd5);
    check("restart_sof", {31'd0, sof_err}, 32'd1);
    @(posedge aclk); #1;
    pulse_clr();

    // Randomised frames with occasional framing faults and error clears
    for (int f = 0; f < 24; f++) begin
      stall_en = 1'($urandom % 2);
      for (int i = 0; i < H * V; i++) begin
        logic u, l;
        u = (i == 0);
        l = ((i % H) == H - 1);
        if ($urandom % 40 == 0) u = ~u;
        if ($urandom % 40 == 0) l = ~l;
        if ($urandom % 4 == 0) idle($urandom_range(1, 3));
        err_clr = ($urandom % 16 == 0);
        send_beat($urandom, u, l);
        err_clr = 0;
      end
      idle($urandom_range(0, 2));
    end
    stall_en = 0;
    pulse_clr();
    idle(2);

    // Reset in the middle of a frame, at pixel (2,1)
    for (int i = 0; i < 6; i++) send_beat(i + 1, i == 0, i == 3);
    tvalid = 0;
    aresetn = 0;
    @(negedge aclk);
    check("mid_rst_tready", {31'd0, tready}, 32'd0);
    check("mid_rst_fc", {16'd0, frame_count}, 32'd0);
    check("mid_rst_cs", checksum, 32'd0);
    check("mid_rst_flags", {28'd0, checksum_valid, sof_err, eol_early_err, eol_late_err}, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1;
    @(negedge aclk);
    check("mid_rel_tready0", {31'd0, tready}, 32'd0);
    @(posedge aclk); #1;
    send_beat(32'hDEAD_BEEF, 1'b0, 1'b0);
    tvalid = 0;
    @(negedge aclk);
    check("post_rst_drop", {31'd0, sof_err}, 32'd0);
    @(posedge aclk); #1;
    send_frame(32'd1, 0);
    frame_done("post_rst", 32'd78, 16'd1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
